// File: rtl/simd_compare_pipe_if.sv
// Operand/result handshake bundle for simd_compare_pipe.
// The master drives operations and consumes results; the slave is the comparator.
interface simd_compare_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [1:0]            sew;
  logic [2:0]            op;
  logic                  sign;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_err;

  modport master (
    output in_valid, operand_a, operand_b, sew, op, sign, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, operand_a, operand_b, sew, op, sign, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/simd_compare_pipe.sv
// Two-stage SIMD integer comparator (EQ/NE/LT/LE/GT/GE) for 8/16/32/64-bit elements.
// Define SIMD_CMP_MINMAX_EN to enable element-wise MIN/MAX on op 6/7.
module simd_compare_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 6
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  simd_compare_pipe_if.slave bus
);
  localparam int NB      = DATA_WIDTH / 8;
  localparam int LOG_NB  = $clog2(NB);
  localparam int MAX_SEW = (LOG_NB < 3) ? LOG_NB : 3;

`ifdef SIMD_CMP_MINMAX_EN
  localparam logic MINMAX_ON = 1'b1;
`else
  localparam logic MINMAX_ON = 1'b0;
`endif

  // ltt/gtt follow the element's top byte, which carries the signed compare when requested.
  typedef struct packed {
    logic [NB-1:0] eq;
    logic [NB-1:0] ltu;
    logic [NB-1:0] gtu;
    logic [NB-1:0] ltt;
    logic [NB-1:0] gtt;
  } lvl_t;

  function automatic lvl_t combine(input lvl_t c);
    lvl_t r;
    r = '0;
    for (int j = 0; j < NB / 2; j++) begin
      r.eq[j]  = c.eq[2*j+1] & c.eq[2*j];
      r.ltu[j] = c.ltu[2*j+1] | (c.eq[2*j+1] & c.ltu[2*j]);
      r.gtu[j] = c.gtu[2*j+1] | (c.eq[2*j+1] & c.gtu[2*j]);
      r.ltt[j] = c.ltt[2*j+1] | (c.eq[2*j+1] & c.ltu[2*j]);
      r.gtt[j] = c.gtt[2*j+1] | (c.eq[2*j+1] & c.gtu[2*j]);
    end
    return r;
  endfunction

  // Handshake
  logic stall;
  logic accept;
  logic advance;
  logic s1_valid_reg;
  logic out_valid_reg;

  assign stall        = out_valid_reg & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~flush;
  assign accept       = bus.in_valid & bus.in_ready;
  assign advance      = s1_valid_reg & ~stall & ~flush;

  // Stage 1 byte compares
  logic [NB-1:0] byte_eq;
  logic [NB-1:0] byte_ltu;
  logic [NB-1:0] byte_gtu;
  logic [NB-1:0] byte_ltt;
  logic [NB-1:0] byte_gtt;
  logic [NB-1:0] byte_top;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam logic TOP1 = ((gi % 2) == 1);
      localparam logic TOP2 = ((gi % 4) == 3);
      localparam logic TOP3 = ((gi % 8) == 7);
      logic [7:0] a_byte;
      logic [7:0] b_byte;
      assign a_byte = bus.operand_a[8*gi +: 8];
      assign b_byte = bus.operand_b[8*gi +: 8];
      assign byte_eq[gi]  = (a_byte == b_byte);
      assign byte_ltu[gi] = (a_byte < b_byte);
      assign byte_gtu[gi] = (a_byte > b_byte);
      assign byte_top[gi] = (bus.sew == 2'd0)
                          | ((bus.sew == 2'd1) & TOP1)
                          | ((bus.sew == 2'd2) & TOP2)
                          | ((bus.sew == 2'd3) & TOP3);
      assign byte_ltt[gi] = byte_top[gi] &
                            (bus.sign ? ($signed(a_byte) < $signed(b_byte)) : (a_byte < b_byte));
      assign byte_gtt[gi] = byte_top[gi] &
                            (bus.sign ? ($signed(a_byte) > $signed(b_byte)) : (a_byte > b_byte));
    end
  endgenerate

  logic in_err;
  assign in_err = (int'(bus.sew) > MAX_SEW) | ((bus.op[2:1] == 2'b11) & ~MINMAX_ON);

  logic [NB-1:0]        s1_eq_reg;
  logic [NB-1:0]        s1_ltu_reg;
  logic [NB-1:0]        s1_gtu_reg;
  logic [NB-1:0]        s1_ltt_reg;
  logic [NB-1:0]        s1_gtt_reg;
  logic [1:0]           s1_sew_reg;
  logic [2:0]           s1_op_reg;
  logic                 s1_err_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_eq_reg    <= '0;
      s1_ltu_reg   <= '0;
      s1_gtu_reg   <= '0;
      s1_ltt_reg   <= '0;
      s1_gtt_reg   <= '0;
      s1_sew_reg   <= '0;
      s1_op_reg    <= '0;
      s1_err_reg   <= 1'b0;
      s1_tag_reg   <= '0;
    end else begin
      if (flush) begin
        s1_valid_reg <= 1'b0;
      end else if (!stall) begin
        s1_valid_reg <= accept;
      end
      if (accept) begin
        s1_eq_reg  <= byte_eq;
        s1_ltu_reg <= byte_ltu;
        s1_gtu_reg <= byte_gtu;
        s1_ltt_reg <= byte_ltt;
        s1_gtt_reg <= byte_gtt;
        s1_sew_reg <= bus.sew;
        s1_op_reg  <= bus.op;
        s1_err_reg <= in_err;
        s1_tag_reg <= bus.in_tag;
      end
    end
  end

`ifdef SIMD_CMP_MINMAX_EN
  // Operands are only carried forward when MIN/MAX needs to select them.
  logic [DATA_WIDTH-1:0] s1_a_reg;
  logic [DATA_WIDTH-1:0] s1_b_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_a_reg <= '0;
      s1_b_reg <= '0;
    end else if (accept) begin
      s1_a_reg <= bus.operand_a;
      s1_b_reg <= bus.operand_b;
    end
  end
`endif

  // Stage 2 hierarchical combine
  lvl_t                  lvl [0:3];
  lvl_t                  cur;
  logic [NB-1:0]         le;
  logic [NB-1:0]         ge;
  logic [NB-1:0]         cmp;
  logic [NB-1:0]         emask;
  logic [DATA_WIDTH-1:0] data_next;

  always_comb begin
    lvl[0] = '{eq: s1_eq_reg, ltu: s1_ltu_reg, gtu: s1_gtu_reg,
               ltt: s1_ltt_reg, gtt: s1_gtt_reg};
    lvl[1] = combine(lvl[0]);
    lvl[2] = combine(lvl[1]);
    lvl[3] = combine(lvl[2]);
    cur    = lvl[s1_sew_reg];
    le     = cur.ltt | cur.eq;
    ge     = cur.gtt | cur.eq;
    for (int i = 0; i < NB; i++) begin
      emask[i] = (i < (NB >> s1_sew_reg));
    end
    case (s1_op_reg)
      3'd0:    cmp = cur.eq;
      3'd1:    cmp = ~cur.eq;
      3'd2:    cmp = cur.ltt;
      3'd3:    cmp = le;
      3'd4:    cmp = cur.gtt;
      3'd5:    cmp = ge;
      default: cmp = '0;
    endcase
    data_next = '0;
    data_next[NB-1:0] = cmp & emask;
`ifdef SIMD_CMP_MINMAX_EN
    if (s1_op_reg[2:1] == 2'b11) begin
      for (int k = 0; k < NB; k++) begin
        logic [LOG_NB-1:0] idx;
        logic              take_a;
        idx    = LOG_NB'(k >> s1_sew_reg);
        take_a = s1_op_reg[0] ? ge[idx] : le[idx];
        data_next[8*k +: 8] = take_a ? s1_a_reg[8*k +: 8] : s1_b_reg[8*k +: 8];
      end
    end
`endif
    if (s1_err_reg) begin
      data_next = '0;
    end
  end

  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [TAG_WIDTH-1:0]  out_tag_reg;
  logic                  out_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (!stall) begin
        out_valid_reg <= s1_valid_reg;
      end
      if (advance) begin
        out_data_reg <= data_next;
        out_tag_reg  <= s1_tag_reg;
        out_err_reg  <= s1_err_reg;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_tag   = out_tag_reg;
  assign bus.out_err   = out_err_reg;
endmodule

// File: tb/tb_simd_compare_pipe.sv
// Randomized + directed bench for simd_compare_pipe (DATA_WIDTH=64) against an
// element-level arithmetic model with an in-order expectation queue.
module tb_simd_compare_pipe;
  localparam int DW = 64;
  localparam int TW = 6;

`ifdef SIMD_CMP_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  simd_compare_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

  simd_compare_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic [5:0]  tag;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  logic [5:0]  seen_tags[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic [63:0] last_data = '0;
  logic        last_err = 1'b0;
  logic [5:0]  last_tag = '0;
  int          last_lat = 0;
  logic [5:0]  tag_cnt = 6'd10;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Element-level reference: signed order is preserved by biasing the sign bit.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                                 input logic [2:0] o, input logic sg, input logic [5:0] t,
                                 input int c);
    exp_t r;
    int w;
    int n;
    logic [63:0] m, top, ua, ub, ea, eb, pick;
    logic res;
    w = 8 << s;
    n = 64 / w;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    top = 64'd1 << (w - 1);
    r.data = '0;
    r.err = 1'b0;
    r.tag = t;
    r.acc_cyc = c;
    if (o >= 3'd6 && !MINMAX) begin
      r.err = 1'b1;
      return r;
    end
    for (int e = 0; e < n; e++) begin
      ua = (a >> (e * w)) & m;
      ub = (b >> (e * w)) & m;
      ea = sg ? (ua ^ top) : ua;
      eb = sg ? (ub ^ top) : ub;
      case (o)
        3'd0:    res = (ea == eb);
        3'd1:    res = (ea != eb);
        3'd2:    res = (ea < eb);
        3'd3:    res = (ea <= eb);
        3'd4:    res = (ea > eb);
        3'd5:    res = (ea >= eb);
        default: res = 1'b0;
      endcase
      if (o < 3'd6) begin
        r.data[e] = res;
      end else begin
        pick = (o == 3'd6) ? ((ea <= eb) ? ua : ub) : ((ea >= eb) ? ua : ub);
        r.data = r.data | (pick << (e * w));
      end
    end
    return r;
  endfunction

  task automatic monitor();
    cyc++;
    if (!rst_n) begin
      q.delete();
      return;
    end
    if (flush) begin
      check("flush_in_ready", bus.in_ready, 0);
      q.delete();
    end else begin
      if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
      else check("in_ready_free", bus.in_ready, 1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 0);
        end else begin
          check("out_data", bus.out_data, q[0].data);
          check("out_err", bus.out_err, q[0].err);
          check("out_tag", bus.out_tag, q[0].tag);
          if (bus.out_ready) begin
            last_data = bus.out_data;
            last_err  = bus.out_err;
            last_tag  = bus.out_tag;
            last_lat  = cyc - q[0].acc_cyc;
            seen_tags.push_back(bus.out_tag);
            n_out++;
            $display("txn tag=%0d data=0x%016h err=%0d lat=%0d", bus.out_tag, bus.out_data,
                     bus.out_err, last_lat);
            void'(q.pop_front());
          end
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.operand_a, bus.operand_b, bus.sew, bus.op, bus.sign, bus.in_tag, cyc));
      n_acc++;
    end
  endtask

  task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] s, input logic [2:0] o, input logic sg,
                      input logic [5:0] t, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.sew       = s;
    bus.op        = o;
    bus.sign      = sg;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] s, input logic [2:0] o, input logic sg,
                          input logic [63:0] exp_data, input logic exp_err);
    tag_cnt = tag_cnt + 6'd1;
    step(1'b1, a, b, s, o, sg, tag_cnt, 1'b1, 1'b0);
    idle(2);
    check({name, "_tag"}, last_tag, tag_cnt);
    check({name, "_data"}, last_data, exp_data);
    check({name, "_err"}, last_err, exp_err);
    check({name, "_latency"}, last_lat, 2);
  endtask

  function automatic logic [63:0] rand_b(input logic [63:0] a);
    logic [63:0] r;
    case ($urandom_range(0, 2))
      0:       r = {$urandom(), $urandom()};
      1:       r = a;
      default: r = a ^ (64'hFF << (8 * $urandom_range(0, 7)));
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    int k, n0, n_out0;

    bus.in_valid = 1'b0; bus.operand_a = '0; bus.operand_b = '0; bus.sew = '0;
    bus.op = '0; bus.sign = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_err", bus.out_err, 0);
    rst_n = 1'b1;
    idle(1);

    directed("lt64_signed", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd3, 3'd2, 1'b1, 64'h1, 1'b0);
    directed("lt64_unsigned", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd3, 3'd2, 1'b0, 64'h0, 1'b0);
    directed("lt16_low_byte", 64'h80, 64'h1, 2'd1, 3'd2, 1'b1, 64'h0, 1'b0);
    directed("ne8", 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0709, 2'd0, 3'd1, 1'b0, 64'h01, 1'b0);
    directed("ne32", 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0709, 2'd2, 3'd1, 1'b0, 64'h1, 1'b0);
    directed("ge32", 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0709, 2'd2, 3'd5, 1'b0, 64'h2, 1'b0);
    if (MINMAX) directed("max8", 64'h807F_0001_FF02_1020, 64'h0080_0100_01FF_2010, 2'd0, 3'd7, 1'b1,
                         64'h007F_0101_0102_2020, 1'b0);
    else directed("max8_disabled", 64'h807F_0001_FF02_1020, 64'h0080_0100_01FF_2010, 2'd0, 3'd7, 1'b1,
                  64'h0, 1'b1);

    // Back-pressure: three back-to-back ops, consumer stalled
    seen_tags.delete();
    n0 = n_acc;
    k = 1;
    a = {$urandom(), $urandom()};
    b = rand_b(a);
    for (int i = 0; i < 6; i++) begin
      step(k <= 3, a, b, 2'd0, 3'd0, 1'b0, 6'(k), 1'b0, 1'b0);
      if (n_acc - n0 >= k) begin
        k++;
        a = {$urandom(), $urandom()};
        b = rand_b(a);
      end
    end
    check("bp_stalled_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 20 && (k <= 3 || q.size() > 0); i++) begin
      step(k <= 3, a, b, 2'd0, 3'd0, 1'b0, 6'(k), 1'b1, 1'b0);
      if (n_acc - n0 >= k) begin
        k++;
        a = {$urandom(), $urandom()};
        b = rand_b(a);
      end
    end
    check("bp_drain", q.size(), 0);
    check("bp_count", seen_tags.size(), 3);
    if (seen_tags.size() == 3) begin
      for (int i = 0; i < 3; i++) check("bp_tag_order", seen_tags[i], 64'(i + 1));
    end

    // Flush with two ops in flight
    n_out0 = n_out;
    step(1'b1, 64'h5, 64'h5, 2'd0, 3'd0, 1'b0, 6'd40, 1'b1, 1'b0);
    step(1'b1, 64'h6, 64'h6, 2'd0, 3'd0, 1'b0, 6'd41, 1'b1, 1'b0);
    step(1'b0, '0, '0, 2'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b1);
    check("flush_out_valid", bus.out_valid, 0);
    idle(4);
    check("flush_no_emit", n_out - n_out0, 0);

    // Reset in the middle of traffic
    step(1'b1, 64'h1234, 64'h1234, 2'd0, 3'd0, 1'b0, 6'd50, 1'b1, 1'b0);
    step(1'b1, 64'h7, 64'h7, 2'd0, 3'd0, 1'b0, 6'd51, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b0, '0, '0, 2'd0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_tag", bus.out_tag, 0);
    check("midrst_out_err", bus.out_err, 0);
    rst_n = 1'b1;
    n_out0 = n_out;
    idle(4);
    check("midrst_no_emit", n_out - n_out0, 0);

    // Randomized traffic with back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      a = {$urandom(), $urandom()};
      b = rand_b(a);
      step($urandom_range(0, 9) < 7, a, b, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 2);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    check("rand_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simd_compare_pipe.md
Name: simd_compare_pipe

Overview:
- Pipelined, parametrised SIMD integer comparator for the vector lane.
- Supports element widths 8/16/32/64 (SEW 0..3), bounded by DATA_WIDTH, with signed and unsigned compares.
- Produces either a packed per-element mask or, with the optional feature, element-wise min/max data.
- Two-stage valid/ready pipeline with tag passthrough and flush; sits between the lane operand read stage and the mask/writeback path.

Parameters:
- DATA_WIDTH, 64: operand width in bits; power of two, 16..512, multiple of 8.
- TAG_WIDTH, 6: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  operation valid
- in_ready  out  1  block accepts an operation this cycle
- operand_a  in  DATA_WIDTH  left operand
- operand_b  in  DATA_WIDTH  right operand
- sew  in  2  element width = 8<<sew
- op  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 MIN, 7 MAX
- sign  in  1  1 = signed compare
- in_tag  in  TAG_WIDTH  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  DATA_WIDTH  packed mask or min/max data
- out_tag  out  TAG_WIDTH  tag of the result
- out_err  out  1  illegal sew or op for this configuration

Behaviour:
- Semantics are always "operand_a OP operand_b" per element; N = DATA_WIDTH/(8<<sew) elements.
- Stage 1 (registered):
  - Per-byte unsigned eq/lt/gt, plus signed lt/gt for the top byte of every element only.
  - Captures the operands, sew, op, sign and tag.
- Stage 2 (registered to outputs): hierarchical combine at each width doubling:
  - eq = eq_hi & eq_lo.
  - lt = lt_hi | (eq_hi & lt_lo). Same form for gt.
  - The high half uses signed lt/gt when sign=1. The low half is always unsigned.
  - NE/LE/GE are derived from eq/lt/gt at the selected width, for every sew.
- Compare ops: out_data[i] = result of element i for i<N; bits N..DATA_WIDTH-1 are 0.
- Illegal encodings:
  - sew with (8<<sew) > DATA_WIDTH: out_data=0, out_err=1.
  - op 6/7 without the feature: out_data=0, out_err=1.
- Latency: 2 cycles from accept to out_valid when not stalled; throughput 1 op/cycle.
- Handshake:
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - Accept occurs when in_valid & in_ready.
  - During stall both stages hold and out_data/out_tag/out_err stay stable.
  - out_valid never deasserts without out_ready.
- Simultaneous accept on the input and consume on the output is legal; there is no bubble.
- flush: clears both stage valids next cycle, overriding stall and in_valid. In the flush cycle in_ready=0; the in-flight result is dropped even if out_ready=1.
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_tag=0, out_err=0, all internal valids 0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight ops.
- Data registers update only on accept or advance; valid registers follow the handshake.

Optional Feature:
- Macro: SIMD_CMP_MINMAX_EN.
- Defined: op 6/7 produce per-element min/max, selected from stage-2 lt/gt using the sign setting.
  - MIN selects operand_a when a<=b, else operand_b. MAX selects operand_a when a>=b, else operand_b.
  - All element bits are filled; out_err=0.
- Undefined: op 6/7 produce out_data=0 and out_err=1; no operand datapath registers are inferred beyond those the compare needs.

Test Plan (DATA_WIDTH=64):
- sew=3 LT: a=0xFFFF_FFFF_FFFF_FFFF, b=0.
  - sign=1 -> out_data=0x1 after 2 cycles.
  - sign=0 -> out_data=0x0.
- sew=1 signed LT: a=0x0000_0000_0000_0080, b=0x0000_0000_0000_0001 -> bit0=0, bits1..3=0. This checks that the low byte is compared unsigned.
- sew=0 NE: a=0x0102_0304_0506_0708, b=0x0102_0304_0506_0709 -> out_data=0x01. With sew=2 NE on the same operands -> 0x1. With sew=2 GE -> 0x2.
- Back-pressure: issue 3 back-to-back ops, hold out_ready=0 for 4 cycles.
  - in_ready must drop once out_valid=1.
  - Outputs must be stable, with no loss or duplication.
  - Tags must emerge in order 1,2,3.
- Flush with 2 ops in flight -> out_valid=0 next cycle and no tags emerge. Reset asserted mid-stream -> all outputs 0 next cycle.
- With SIMD_CMP_MINMAX_EN, sew=0 signed MAX: a=0x80_7F_00_01_FF_02_10_20, b=0x00_80_01_00_01_FF_20_10 -> out_data=0x00_7F_01_01_01_02_20_20. Without the macro -> out_data=0, out_err=1.
